// File: rtl/bus_responder.sv
// Memory-side responder for the hmc-6502 bus: one access at a time, programmable wait states, RAM + vector bank.
// Optional `define BUS_RESPONDER_COUNT_EN adds rd_count/wr_count access counters.
module bus_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300,
    parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
    input  logic        ph1,
    input  logic        reset_b,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [3:0]  wait_cfg,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
`ifdef BUS_RESPONDER_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    // Handshake: the requester raises req with rw/addr/wdata/wait_cfg valid and holds
    // req until it sees the one-cycle ack; everything is captured on the IDLE edge.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
`ifdef BUS_RESPONDER_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
`endif

    logic [7:0]  mem [DEPTH];
    logic        is_ram, is_vec, resp_err, mem_we;
    logic [15:0] vec_word;
    logic [7:0]  vec_byte, rd_byte;

    always_comb begin
        is_ram   = ({16'h0000, addr_q} < DEPTH);
        is_vec   = !is_ram && (addr_q >= 16'hFFFA);
        // 0xFFFC/D is the reset vector; NMI (0xFFFA/B) and IRQ (0xFFFE/F) share IRQ_VEC.
        vec_word = (addr_q[2:1] == 2'b10) ? RESET_VEC : IRQ_VEC;
        vec_byte = addr_q[0] ? vec_word[15:8] : vec_word[7:0];
        rd_byte  = is_ram ? mem[addr_q[AW-1:0]] : (is_vec ? vec_byte : OPEN_BUS);
        resp_err = !is_ram && !(is_vec && rw_q);
        mem_we   = reset_b && (state_q == RESP) && !rw_q && is_ram;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
`ifdef BUS_RESPONDER_COUNT_EN
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = req;
                if (req) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (wait_cfg == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = wait_cfg;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                // Outputs are registered, so ack/err/rdata appear in the cycle after RESP,
                // while busy stays high through that cycle.
                busy_d  = 1'b1;
                ack_d   = 1'b1;
                err_d   = resp_err;
                if (rw_q) rdata_d = rd_byte;
                state_d = IDLE;
`ifdef BUS_RESPONDER_COUNT_EN
                if (rw_q) rd_count_d = rd_count_q + 16'd1;
                else      wr_count_d = wr_count_q + 16'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b1;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BUS_RESPONDER_COUNT_EN
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef BUS_RESPONDER_COUNT_EN
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
`endif
        end
    end

    // RAM contents survive reset; a write is dropped if reset hits during RESP.
    always_ff @(posedge ph1) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef BUS_RESPONDER_COUNT_EN
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Randomized self-checking bench for bus_responder against a byte-array reference model.
module tb_bus_responder;

    localparam logic [15:0] RST_V = 16'h0200;
    localparam logic [15:0] IRQ_V = 16'h0300;

    logic        ph1 = 1'b0;
    logic        reset_b = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [3:0]  wait_cfg = 4'd0;
    logic [7:0]  rdata;
    logic        ack, busy, err;
    logic [1:0]  dbg_state;
`ifdef BUS_RESPONDER_COUNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    bus_responder dut (
        .ph1(ph1), .reset_b(reset_b), .req(req), .rw(rw), .addr(addr),
        .wdata(wdata), .wait_cfg(wait_cfg), .rdata(rdata), .ack(ack),
        .busy(busy), .err(err), .dbg_state(dbg_state)
`ifdef BUS_RESPONDER_COUNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata = 8'h00;
    int         ref_rd = 0;
    int         ref_wr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {err, read_data} for an access, straight from the address map.
    function automatic logic [8:0] ref_decode(input logic r, input logic [15:0] a);
        logic [15:0] vw;
        if (a < 16'd256) return {1'b0, ref_mem[a[7:0]]};
        if (a >= 16'hFFFA) begin
            vw = (a == 16'hFFFC || a == 16'hFFFD) ? RST_V : IRQ_V;
            return {!r, (a[0] ? vw[15:8] : vw[7:0])};
        end
        return {1'b1, 8'hFF};
    endfunction

    task automatic do_access(input logic r, input logic [15:0] a, input logic [7:0] d,
                             input logic [3:0] wc, input bit scramble, input string tag);
        logic [8:0] exp;
        int  cyc;
        bit  got;
        bit  wait_ok;
        exp = ref_decode(r, a);
        @(negedge ph1);
        req = 1'b1; rw = r; addr = a; wdata = d; wait_cfg = wc;
        @(posedge ph1); #1;
        cyc = 0; got = 0; wait_ok = 1;
        while (!got && cyc < 40) begin
            if (ack === 1'b1) begin
                got = 1;
            end else begin
                if (busy !== 1'b1 || err !== 1'b0) wait_ok = 0;
                if (scramble) begin
                    addr = 16'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
                    wait_cfg = 4'($urandom); req = 1'($urandom);
                end
                @(posedge ph1); #1;
                cyc++;
            end
        end
        check({tag, "/ack"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(cyc), 32'(wc) + 32'd1);
        check({tag, "/busy_wait"}, 32'(wait_ok), 32'd1);
        check({tag, "/busy_ack"}, 32'(busy), 32'd1);
        check({tag, "/err"}, 32'(err), 32'(exp[8]));
        if (r) begin
            ref_rdata = exp[7:0];
            ref_rd++;
        end else begin
            if (a < 16'd256) ref_mem[a[7:0]] = d;
            ref_wr++;
        end
        check({tag, "/rdata"}, 32'(rdata), 32'(ref_rdata));
        req = 1'b0; rw = 1'b1; addr = 16'($urandom); wdata = 8'($urandom);
        @(posedge ph1); #1;
        check({tag, "/after"}, {29'd0, ack, busy, err}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge ph1);
        reset_b = 1'b0;
        req = 1'b0;
        repeat (2) @(posedge ph1);
        #1;
        check("reset/outs", {20'd0, rdata, ack, busy, err, 1'b0}, 32'd0);
        ref_rdata = 8'h00; ref_rd = 0; ref_wr = 0;
        @(negedge ph1);
        reset_b = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        logic        r;
        int          cat;
        bit          ack_seen;

        apply_reset();

        // Vector reads right after reset.
        do_access(1'b1, 16'hFFFC, 8'h00, 4'd0, 1'b0, "vec_lo");
        do_access(1'b1, 16'hFFFD, 8'h00, 4'd0, 1'b0, "vec_hi");
        do_access(1'b1, 16'hFFFA, 8'h00, 4'd1, 1'b0, "nmi_lo");
        do_access(1'b1, 16'hFFFF, 8'h00, 4'd2, 1'b0, "irq_hi");

        // Give every RAM byte a known value.
        for (int i = 0; i < 256; i++) do_access(1'b0, 16'(i), 8'($urandom), 4'd0, 1'b0, "fill");

        do_access(1'b0, 16'h0010, 8'hA5, 4'd3, 1'b0, "wr_a5");
        do_access(1'b1, 16'h0010, 8'h00, 4'd0, 1'b0, "rd_a5");
        do_access(1'b1, 16'h4000, 8'h00, 4'd0, 1'b0, "rd_unmap");
        do_access(1'b0, 16'hFFFE, 8'h12, 4'd0, 1'b0, "wr_vec");
        do_access(1'b1, 16'hFFFE, 8'h00, 4'd0, 1'b0, "rd_vec");
        do_access(1'b0, 16'h0100, 8'h34, 4'd1, 1'b0, "wr_unmap");
        do_access(1'b1, 16'h00FF, 8'h00, 4'd15, 1'b0, "rd_top");
        do_access(1'b0, 16'h0033, 8'h5C, 4'd5, 1'b1, "wr_scr");
        do_access(1'b1, 16'h0033, 8'h00, 4'd5, 1'b1, "rd_scr");

        // Reset during the WAIT phase of a write abandons it.
        do_access(1'b0, 16'h0020, 8'h11, 4'd0, 1'b0, "pre_rst");
        @(negedge ph1);
        req = 1'b1; rw = 1'b0; addr = 16'h0020; wdata = 8'h77; wait_cfg = 4'd5;
        repeat (3) @(posedge ph1);
        #1;
        check("midrst/busy", 32'(busy), 32'd1);
        reset_b = 1'b0;
        #1;
        check("midrst/outs", {20'd0, rdata, ack, busy, err, 1'b0}, 32'd0);
        req = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge ph1); #1;
            if (ack === 1'b1) ack_seen = 1;
            if (i == 2) reset_b = 1'b1;
        end
        check("midrst/no_ack", 32'(ack_seen), 32'd0);
        ref_rdata = 8'h00; ref_rd = 0; ref_wr = 0;
        do_access(1'b1, 16'h0020, 8'h00, 4'd0, 1'b0, "post_rst");

        // Random mix of RAM, vector and unmapped accesses.
        for (int n = 0; n < 150; n++) begin
            cat = $urandom_range(0, 5);
            if (cat <= 3)      a = 16'($urandom_range(0, 255));
            else if (cat == 4) a = 16'($urandom_range(16'hFFFA, 16'hFFFF));
            else               a = 16'($urandom_range(256, 16'hFFF9));
            r = 1'($urandom);
            do_access(r, a, 8'($urandom), 4'($urandom_range(0, 6)), 1'($urandom), "rand");
        end

`ifdef BUS_RESPONDER_COUNT_EN
        check("cnt/rand_rd", 32'(rd_count), 32'(ref_rd[15:0]));
        check("cnt/rand_wr", 32'(wr_count), 32'(ref_wr[15:0]));
        apply_reset();
        check("cnt/reset", {rd_count, wr_count}, 32'd0);
        do_access(1'b1, 16'h0001, 8'h00, 4'd0, 1'b0, "c_rd1");
        do_access(1'b0, 16'h0002, 8'h9A, 4'd1, 1'b0, "c_wr1");
        do_access(1'b1, 16'hFFFC, 8'h00, 4'd0, 1'b0, "c_rd2");
        do_access(1'b0, 16'h2000, 8'h9B, 4'd0, 1'b0, "c_wr2");
        do_access(1'b1, 16'h5000, 8'h00, 4'd2, 1'b0, "c_rd3");
        check("cnt/rd3", 32'(rd_count), 32'd3);
        check("cnt/wr2", 32'(wr_count), 32'd2);
        @(negedge ph1);
        force dut.rd_count_q = 16'hFFFF;
        @(posedge ph1); #1;
        release dut.rd_count_q;
        ref_rd = 16'hFFFF;
        do_access(1'b1, 16'h0003, 8'h00, 4'd0, 1'b0, "c_wrap");
        check("cnt/wrap", 32'(rd_count), 32'(ref_rd[15:0]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the hmc-6502 CPU bus. It is the target end of the address/data cycles that the control FSM initiates.
- Accepts one request at a time, applies a configurable number of wait states, then returns an ack pulse.
- Reads are served from an internal byte RAM or a fixed vector bank; writes go into the RAM.
- Sits between the core's address/data ports and the simulation or FPGA top level.

Parameters:
- DEPTH, 256: bytes of internal RAM mapped at 0x0000..DEPTH-1; must be a power of two, at most 32768.
- RESET_VEC, 16'h0200: value returned for reads of 0xFFFC (low byte) and 0xFFFD (high byte).
- IRQ_VEC, 16'h0300: value returned for 0xFFFE/0xFFFF; the same value is returned for NMI at 0xFFFA/0xFFFB.
- OPEN_BUS, 8'hFF: read data returned for unmapped addresses.

Ports:
- ph1  input  1  single system clock; all state updates on its rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- req  input  1  CPU request valid; held high until ack.
- rw  input  1  1 = read, 0 = write; sampled with req.
- addr  input  16  byte address; sampled with req.
- wdata  input  8  write data; sampled with req.
- wait_cfg  input  4  wait states per access; sampled with req.
- rdata  output  8  read data.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from request capture through the ack cycle.
- err  output  1  set with ack when the access was unmapped, or was a write to the vector bank.

Behaviour:
- Reset (reset_b low, asynchronous):
  - state = IDLE; rdata = 8'h00; ack = 0; busy = 0; err = 0; wait counter = 0.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req = 1, capture addr, rw, wdata and wait_cfg; set busy = 1.
  - If wait_cfg = 0, go to RESP; otherwise load the counter with wait_cfg and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - wait_cfg = N therefore gives exactly N WAIT cycles.
- RESP:
  - Assert ack for exactly one cycle and perform the access.
  - Read: drive rdata from the decode below. rdata holds its value until the next read's RESP; writes do not disturb it.
  - Write: update RAM[addr] if mapped; rdata is unchanged.
  - busy = 1 in RESP. Next state is IDLE; busy = 0 from the following cycle.
- Latency: req sampled high at edge k gives ack in the cycle after edge k + 1 + wait_cfg.
  - Back-to-back requests have a minimum period of 2 + wait_cfg cycles, because IDLE always costs one cycle.
- Address decode, in priority order:
  - addr < DEPTH: RAM, indexed with addr[log2(DEPTH)-1:0].
  - addr >= 0xFFFA: vector bank, read-only. Low byte at even addresses, high byte at odd addresses. A write sets err = 1 and changes nothing.
  - Otherwise: unmapped. A read returns OPEN_BUS; a write is dropped. err = 1 in both cases.
- err is asserted only in the RESP cycle, coincident with ack; it is 0 otherwise.
- Input changes while busy:
  - Changes to req, addr, rw, wdata and wait_cfg during WAIT/RESP are ignored; only the captured copies are used.
  - req dropping before ack does not abort the access.
- Reset mid-access: the access is abandoned. A pending write is not performed and no ack is issued.
- RAM write and read paths are synchronous to ph1. No read-during-write hazard is possible, since there is one access per transaction.

Optional Feature:
- Macro: BUS_RESPONDER_COUNT_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments by 1 on every RESP of the matching type, including err accesses.
  - Both wrap from 0xFFFF to 0x0000.
  - Both clear on reset_b low.
- Not defined: the ports and counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then read 0xFFFC and 0xFFFD with wait_cfg = 0 -> two acks, rdata 8'h00 then 8'h02, err = 0, ack one cycle after capture.
- Write 8'hA5 to 0x0010 with wait_cfg = 3, then read 0x0010 -> write ack exactly 4 cycles after capture, read returns 8'hA5, busy high for the whole access.
- Read 0x4000 (DEPTH = 256) -> rdata 8'hFF, err = 1 only during the ack cycle. Then write 8'h12 to 0xFFFE -> err = 1 and a following read of 0xFFFE still returns 8'h00.
- Change addr, rw and wdata every cycle during WAIT with wait_cfg = 5 -> the access uses the values captured at request time, and ack arrives 6 cycles after capture.
- Drop reset_b during WAIT of a write of 8'h77 to 0x0020 (old contents 8'h11) -> ack never asserted, outputs at reset values, a later read of 0x0020 returns 8'h11.
- BUS_RESPONDER_COUNT_EN defined: 3 reads and 2 writes (one of them unmapped) -> rd_count = 3, wr_count = 2. Preload 0xFFFF, do one more read -> rd_count = 0.
